stream_array_reader: RTL and testbench

- Read-side sequencer for the stream compute function. It drives the read-address stream and consumes the read-data stream.
- It walks addresses 0..count-1 and re-issues an address whenever the returned word carries the "invalid" flag (bit 31 = 0).
- It forwards only valid words, tagged with their address, to a downstream consumer.
- It replaces the ad-hoc random read driver with a deterministic, flow-controlled stage.

---
 rtl/stream_array_reader_if.sv | 27 ++
 rtl/stream_array_reader.sv | 193 +++++++++++++++++++
 tb/tb_stream_array_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_array_reader_if.sv
// Handshake bundle for stream_array_reader: read-address, read-data and output streams.
// The master modport is the reader itself; the slave modport is its environment.
interface stream_array_reader_if #(
    parameter int AW = 4,
    parameter int DW = 32
) ();
    logic [DW-1:0] ra;
    logic          ra_valid;
    logic          ra_ready;
    logic [DW-1:0] rd;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-2:0] out;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output ra, ra_valid, rd_ready, out, out_addr, out_valid,
        input  ra_ready, rd, rd_valid, out_ready
    );

    modport slave (
        input  ra, ra_valid, rd_ready, out, out_addr, out_valid,
        output ra_ready, rd, rd_valid, out_ready
    );
endinterface

// File: rtl/stream_array_reader.sv
// Read-side sequencer: sweeps addresses 0..count-1, re-issues on invalid words, forwards valid ones.
// Optional STREAM_ARRAY_READER_STATS_EN adds max_wait / max_wait_addr wait-time statistics.
module stream_array_reader #(
    parameter int N         = 16,
    parameter int AW        = 4,
    parameter int DW        = 32,
    parameter int RETRY_GAP = 1,
    parameter int MAX_RETRY = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW:0]           count,
    stream_array_reader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef STREAM_ARRAY_READER_STATS_EN
    ,
    output logic [15:0]           max_wait,
    output logic [AW-1:0]         max_wait_addr
`endif
);
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, EMIT, DONE} state_t;

    state_t        state_reg;
    logic [AW-1:0] addr_reg;
    logic [AW:0]   cnt_reg;
    logic [RW-1:0] retry_reg;
    logic [GW-1:0] gap_reg;
    logic          ra_valid_reg;
    logic          out_valid_reg;
    logic [DW-2:0] out_reg;
    logic [AW-1:0] out_addr_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;

    logic [AW:0]   count_clamped;
    logic [RW-1:0] retry_next;
    logic          retry_hit;
    logic          last_addr;
    logic          start_ok;

    assign count_clamped = (count > (AW+1)'(N)) ? (AW+1)'(N) : count;
    assign retry_next    = retry_reg + 1'b1;
    assign retry_hit     = (retry_next == RW'(MAX_RETRY));
    assign last_addr     = (({1'b0, addr_reg} + (AW+1)'(1)) == cnt_reg);
    assign start_ok      = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            gap_reg       <= '0;
            ra_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_addr_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_reg   <= count_clamped;
                        addr_reg  <= '0;
                        retry_reg <= '0;
                        err_reg   <= 1'b0;
                        if (count_clamped == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg    <= ISSUE;
                            ra_valid_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            done_reg     <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.ra_ready) begin
                        ra_valid_reg <= 1'b0;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.rd_valid) begin
                        if (bus.rd[DW-1]) begin
                            out_reg       <= bus.rd[DW-2:0];
                            out_addr_reg  <= addr_reg;
                            out_valid_reg <= 1'b1;
                            state_reg     <= EMIT;
                        end else begin
                            retry_reg <= retry_next;
                            if (retry_hit) begin
                                err_reg   <= 1'b1;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= DONE;
                            end else if (RETRY_GAP == 0) begin
                                ra_valid_reg <= 1'b1;
                                state_reg    <= ISSUE;
                            end else begin
                                gap_reg   <= '0;
                                state_reg <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        ra_valid_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        retry_reg     <= '0;
                        if (last_addr) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            addr_reg     <= addr_reg + 1'b1;
                            ra_valid_reg <= 1'b1;
                            state_reg    <= ISSUE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ra        = DW'(addr_reg);
    assign bus.ra_valid  = ra_valid_reg;
    assign bus.rd_ready  = (state_reg == WAIT);
    assign bus.out       = out_reg;
    assign bus.out_addr  = out_addr_reg;
    assign bus.out_valid = out_valid_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;

`ifdef STREAM_ARRAY_READER_STATS_EN
    // Per-address wait counter; folded into the maximum when the address leaves WAIT for good.
    logic [15:0]   wait_reg;
    logic [15:0]   max_wait_reg;
    logic [AW-1:0] max_addr_reg;
    logic [15:0]   wait_now;
    logic          wait_exit;

    assign wait_now  = (wait_reg == 16'hFFFF) ? wait_reg : wait_reg + 16'd1;
    assign wait_exit = (state_reg == WAIT) && bus.rd_valid && (bus.rd[DW-1] || retry_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg     <= '0;
            max_wait_reg <= '0;
            max_addr_reg <= '0;
        end else if (start_ok) begin
            wait_reg     <= '0;
            max_wait_reg <= '0;
            max_addr_reg <= '0;
        end else if (wait_exit) begin
            wait_reg <= '0;
            if (wait_now > max_wait_reg) begin
                max_wait_reg <= wait_now;
                max_addr_reg <= addr_reg;
            end
        end else if ((state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == GAP)) begin
            wait_reg <= wait_now;
        end
    end

    assign max_wait      = max_wait_reg;
    assign max_wait_addr = max_addr_reg;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif
endmodule

// File: tb/tb_stream_array_reader.sv
// Self-checking bench for stream_array_reader: directed sweep table, randomized sweeps and a mid-sweep reset.
module tb_stream_array_reader;
    localparam int MAXR = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic       err;
`ifdef STREAM_ARRAY_READER_STATS_EN
    logic [15:0] max_wait;
    logic [3:0]  max_wait_addr;
`endif

    stream_array_reader_if #(.AW(4), .DW(32)) bus ();

    stream_array_reader #(
        .N(16), .AW(4), .DW(32), .RETRY_GAP(1), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .count(count),
        .bus(bus),
        .busy(busy),
        .done(done),
        .err(err)
`ifdef STREAM_ARRAY_READER_STATS_EN
        ,
        .max_wait(max_wait),
        .max_wait_addr(max_wait_addr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          a;
        logic [30:0] d;
    } got_t;

    int vectors = 0;
    int miscompares = 0;

    // Upstream memory model: mem holds payloads, an address answers invalid until inv_used reaches inv_target.
    logic [30:0] mem[16];
    int          inv_target[16];
    int          inv_used[16];
    int          reads[16];
    got_t        got[$];
    bit          stall;
    bit          hold7;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Environment: drives ra_ready/rd/rd_valid/out_ready at negedge, observes handshakes 1 unit later.
    initial begin
        bit          pending;
        int          pend_addr;
        bit          ra_hold;
        bit          out_hold;
        logic [31:0] ra_prev;
        logic [30:0] out_prev;
        logic [3:0]  oa_prev;
        pending = 0; pend_addr = 0; ra_hold = 0; out_hold = 0;
        ra_prev = '0; out_prev = '0; oa_prev = '0;
        for (int a = 0; a < 16; a++) begin
            inv_used[a] = 0;
            reads[a] = 0;
        end
        bus.ra_ready = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.ra_ready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (hold7 && bus.out_valid && bus.out_addr == 4'd7) bus.out_ready = 1'b0;
                if (!pending) begin
                    bus.rd_valid = 1'b0;
                end else if (!bus.rd_valid && (!stall || $urandom_range(0, 2) != 0)) begin
                    bus.rd_valid = 1'b1;
                    bus.rd = {(inv_used[pend_addr] >= inv_target[pend_addr]), mem[pend_addr]};
                end
            end
            #1;
            if (rst) begin
                pending = 0; ra_hold = 0; out_hold = 0;
                bus.rd_valid = 1'b0;
            end else begin
                if (ra_hold) begin
                    chk("ra_valid_held", bus.ra_valid, 1);
                    chk("ra_stable", bus.ra, ra_prev);
                end
                if (out_hold) begin
                    chk("out_valid_held", bus.out_valid, 1);
                    chk("out_stable", bus.out, out_prev);
                    chk("out_addr_stable", bus.out_addr, oa_prev);
                end
                if (bus.ra_valid && bus.ra_ready) begin
                    chk("one_outstanding", pending, 0);
                    pending = 1;
                    pend_addr = int'(bus.ra[3:0]);
                    reads[pend_addr]++;
                end else if (bus.rd_valid && bus.rd_ready) begin
                    if (!bus.rd[31]) inv_used[pend_addr]++;
                    pending = 0;
                end
                if (bus.out_valid && bus.out_ready) got.push_back('{int'(bus.out_addr), bus.out});
                ra_hold  = bus.ra_valid && !bus.ra_ready;
                out_hold = bus.out_valid && !bus.out_ready;
                ra_prev  = bus.ra;
                out_prev = bus.out;
                oa_prev  = bus.out_addr;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ra"}, bus.ra, 0);
        chk({tag, "_ra_valid"}, bus.ra_valid, 0);
        chk({tag, "_rd_ready"}, bus.rd_ready, 0);
        chk({tag, "_out"}, bus.out, 0);
        chk({tag, "_out_addr"}, bus.out_addr, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // One sweep: reference model predicts outputs/reads from count and invalid budgets, then compares.
    task automatic run_sweep(input int cnt, input bit stl, input bit poke, input int exp_edges,
                             input int exp_outs, input int exp_err, input string tag);
        int n;
        int edges;
        int base_got;
        int nget;
        int exp_q[$];
        bit m_err;
        int exp_reads[16];
        int base_reads[16];
        n = (cnt > 16) ? 16 : cnt;
        m_err = 0;
        for (int a = 0; a < 16; a++) begin
            exp_reads[a] = 0;
            base_reads[a] = reads[a];
        end
        for (int a = 0; a < n; a++) begin
            int k;
            k = inv_target[a] - inv_used[a];
            if (k >= MAXR) begin
                m_err = 1;
                exp_reads[a] = MAXR;
                break;
            end
            exp_reads[a] = k + 1;
            exp_q.push_back(a);
        end
        base_got = got.size();
        stall = stl;
        @(negedge clk);
        start = 1'b1;
        count = 5'(cnt);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (!done && edges < 5000) begin
            if (poke && edges == 5) begin
                start = 1'b1;
                count = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        #2;
        chk({tag, "_no_timeout"}, (edges < 5000), 1);
        if (exp_edges >= 0) chk({tag, "_latency"}, edges, exp_edges);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, m_err);
        if (exp_err >= 0) chk({tag, "_table_err"}, err, exp_err);
        nget = got.size() - base_got;
        if (exp_outs >= 0) chk({tag, "_table_outs"}, nget, exp_outs);
        chk({tag, "_out_count"}, nget, exp_q.size());
        for (int i = 0; i < nget && i < exp_q.size(); i++) begin
            chk({tag, "_out_addr"}, got[base_got + i].a, exp_q[i]);
            chk({tag, "_out_data"}, got[base_got + i].d, mem[exp_q[i]]);
        end
        for (int a = 0; a < 16; a++) chk({tag, "_reads"}, reads[a] - base_reads[a], exp_reads[a]);
        $display("sweep %s: count=%0d outs=%0d edges=%0d err=%0b", tag, cnt, nget, edges, err);
    endtask

    task automatic setup_mem(input int bad_addr, input int bad_n, input bit rnd);
        for (int a = 0; a < 16; a++) begin
            mem[a] = rnd ? 31'($urandom) : 31'(a + 1);
            if (rnd) inv_target[a] = inv_used[a] + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            else     inv_target[a] = inv_used[a] + ((a == bad_addr) ? bad_n : 0);
        end
    endtask

    typedef struct {
        int cnt;
        int bad_addr;
        int bad_n;
        bit stl;
        bit poke;
        int exp_outs;
        int exp_err;
        int exp_edges;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   w;
        vt[0] = '{16, -1, 0, 1'b0, 1'b0, 16, 0, 48};
        vt[1] = '{16,  5, 2, 1'b0, 1'b0, 16, 0, 54};
        vt[2] = '{ 8,  2, 5, 1'b0, 1'b0,  2, 1, 14};
        vt[3] = '{ 0, -1, 0, 1'b0, 1'b0,  0, 0,  0};
        vt[4] = '{20, -1, 0, 1'b0, 1'b0, 16, 0, 48};
        vt[5] = '{10,  3, 1, 1'b1, 1'b1, 10, 0, -1};
        vt[6] = '{ 1, -1, 0, 1'b0, 1'b0,  1, 0,  3};

        void'($urandom(42));
        stall = 0; hold7 = 0;
        start = 1'b0; count = '0;
        for (int a = 0; a < 16; a++) begin
            inv_target[a] = 0;
            mem[a] = '0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            setup_mem(vt[i].bad_addr, vt[i].bad_n, 1'b0);
            run_sweep(vt[i].cnt, vt[i].stl, vt[i].poke, vt[i].exp_edges,
                      vt[i].exp_outs, vt[i].exp_err, $sformatf("table%0d", i));
`ifdef STREAM_ARRAY_READER_STATS_EN
            if (i == 1) begin
                chk("stats_max_wait", max_wait, 8);
                chk("stats_max_wait_addr", max_wait_addr, 5);
            end
`endif
        end

        for (int r = 0; r < 25; r++) begin
            setup_mem(-1, 0, 1'b1);
            run_sweep($urandom_range(0, 20), 1'(($urandom_range(0, 1))), 1'b0, -1, -1, -1,
                      $sformatf("rand%0d", r));
        end

        // Reset while address 7 sits in EMIT with out_ready held low.
        setup_mem(-1, 0, 1'b0);
        stall = 0;
        hold7 = 1;
        @(negedge clk);
        start = 1'b1;
        count = 5'd16;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(bus.out_valid && bus.out_addr == 4'd7) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("reach_emit7", (w < 500), 1);
        #2 rst = 1'b1;
        #1 check_reset("midsweep_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold7 = 0;
`ifdef STREAM_ARRAY_READER_STATS_EN
        chk("stats_after_reset", max_wait, 0);
`endif
        run_sweep(4, 1'b0, 1'b0, 12, 4, 0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
